// File: rtl/pix_pkg.sv
// Shared types and default widths for the pixel return path.
// The defaults match the work dispatcher, so both ends agree on frame geometry.
package pix_pkg;

  localparam int unsigned DEF_X_BITS     = 4;
  localparam int unsigned DEF_Y_BITS     = 4;
  localparam int unsigned DEF_ITER_BITS  = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_ADDR_BITS  = DEF_X_BITS + DEF_Y_BITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // One buffered pixel at the default widths.
  typedef struct packed {
    logic [DEF_ADDR_BITS-1:0] addr;
    logic [DEF_ITER_BITS-1:0] iter;
  } pix_entry_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO with a power-of-two depth. A synchronous clear empties it
// at frame start. An asynchronous active-high reset also empties it.
module pix_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pix_collect.sv
// Collects worker pixel results, buffers them, and writes each one to the frame buffer
// at the linear address y*(x_max+1)+x. Signals frame completion after the final pixel.
module pix_collect
  import pix_pkg::*;
#(
  parameter int unsigned NUM_X_BITS = DEF_X_BITS,
  parameter int unsigned NUM_Y_BITS = DEF_Y_BITS,
  parameter int unsigned ITER_BITS  = DEF_ITER_BITS,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned ADDR_BITS  = NUM_X_BITS + NUM_Y_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_X_BITS-1:0] x_max,
  input  logic [NUM_Y_BITS-1:0] y_max,
  input  logic                  res_valid,
  output logic                  res_ready,
  input  logic [NUM_X_BITS-1:0] res_x,
  input  logic [NUM_Y_BITS-1:0] res_y,
  input  logic [ITER_BITS-1:0]  res_iter,
  output logic                  mem_wr_req,
  output logic [ADDR_BITS-1:0]  mem_wr_addr,
  output logic [ITER_BITS-1:0]  mem_wr_data,
  input  logic                  mem_wr_ack,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  range_err,
  output logic [ADDR_BITS:0]    pix_count
);

  localparam int unsigned TOT_W = ADDR_BITS + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [ITER_BITS-1:0] iter;
  } entry_t;

  state_t                state_q, state_d;
  logic [NUM_X_BITS-1:0] x_max_q, x_max_d;
  logic [NUM_Y_BITS-1:0] y_max_q, y_max_d;
  logic [TOT_W-1:0]      total_q, total_d;
  logic [TOT_W-1:0]      pix_count_q, pix_count_d;
  logic                  range_err_q, range_err_d;
  logic                  req_q, req_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [ITER_BITS-1:0]  data_q, data_d;
  logic                  frame_done_q, frame_done_d;

  entry_t            push_entry, head_entry;
  logic              fifo_push, fifo_pop, fifo_clr;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              accept, in_range, wr_done, last_wr;

  pix_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(entry_t))
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (fifo_clr),
    .push_i (fifo_push),
    .pop_i  (fifo_pop),
    .din_i  (push_entry),
    .dout_o (head_entry),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign res_ready = (state_q == RUN) && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign accept    = res_valid && res_ready;
  assign in_range  = (res_x <= x_max_q) && (res_y <= y_max_q);
  assign wr_done   = req_q && mem_wr_ack;
  assign last_wr   = wr_done && ((pix_count_q + TOT_W'(1)) == total_q);

  // Address arithmetic wraps modulo 2^ADDR_BITS, which is the required truncation.
  assign push_entry.addr = ADDR_BITS'(res_y) * (ADDR_BITS'(x_max_q) + ADDR_BITS'(1))
                         + ADDR_BITS'(res_x);
  assign push_entry.iter = res_iter;

  // NOTE: every signal written below gets its default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    x_max_d      = x_max_q;
    y_max_d      = y_max_q;
    total_d      = total_q;
    pix_count_d  = pix_count_q;
    range_err_d  = range_err_q;
    req_d        = req_q;
    addr_d       = addr_q;
    data_d       = data_q;
    frame_done_d = 1'b0;
    fifo_push    = accept && in_range && !fifo_full;
    fifo_pop     = 1'b0;
    fifo_clr     = 1'b0;

    if (accept && !in_range) range_err_d = 1'b1;

    if (wr_done) begin
      pix_count_d = pix_count_q + TOT_W'(1);
      req_d       = 1'b0;
    end

    // Load the write register when it is free or finishing, unless the frame just completed.
    if ((state_q == RUN) && (!req_q || wr_done) && !fifo_empty && !last_wr) begin
      fifo_pop = 1'b1;
      req_d    = 1'b1;
      addr_d   = head_entry.addr;
      data_d   = head_entry.iter;
    end

    case (state_q)
      RUN: begin
        if (last_wr) begin
          state_d      = DONE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        if (start) begin
          state_d     = RUN;
          x_max_d     = x_max;
          y_max_d     = y_max;
          total_d     = (TOT_W'(x_max) + TOT_W'(1)) * (TOT_W'(y_max) + TOT_W'(1));
          pix_count_d = '0;
          range_err_d = 1'b0;
          fifo_clr    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_max_q      <= '0;
      y_max_q      <= '0;
      total_q      <= '0;
      pix_count_q  <= '0;
      range_err_q  <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_max_q      <= x_max_d;
      y_max_q      <= y_max_d;
      total_q      <= total_d;
      pix_count_q  <= pix_count_d;
      range_err_q  <= range_err_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign mem_wr_req  = req_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign busy        = (state_q == RUN);
  assign frame_done  = frame_done_q;
  assign range_err   = range_err_q;
  assign pix_count   = pix_count_q;

endmodule

// File: doc/pix_collect.md
Name: pix_collect

Overview:
- Return-path counterpart to the work dispatcher's pixel coordinate generator.
- Accepts computed pixel results (x, y, iteration count) from the compute workers over a valid/ready handshake and buffers them in a small FIFO.
- Converts each coordinate to a linear frame-buffer address and writes it out through a req/ack memory port.
- Counts written pixels and signals frame completion once every pixel of the (x_max+1)*(y_max+1) frame has been written.

Parameters:
- NUM_X_BITS, 4, width of x coordinate and x_max.
- NUM_Y_BITS, 4, width of y coordinate and y_max.
- ITER_BITS, 8, width of the iteration-count result and of the memory write data.
- FIFO_DEPTH, 4, result buffer entries; power of two, at least 2.
- ADDR_BITS, NUM_X_BITS+NUM_Y_BITS, width of the linear frame address.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches x_max/y_max, clears counters, enters RUN.
- x_max  in  NUM_X_BITS  last x index of the frame.
- y_max  in  NUM_Y_BITS  last y index of the frame.
- res_valid  in  1  worker result valid.
- res_ready  out  1  collector can accept a result.
- res_x  in  NUM_X_BITS  result x coordinate.
- res_y  in  NUM_Y_BITS  result y coordinate.
- res_iter  in  ITER_BITS  result iteration count.
- mem_wr_req  out  1  write request, held until acked.
- mem_wr_addr  out  ADDR_BITS  linear address y*(x_max+1)+x.
- mem_wr_data  out  ITER_BITS  iteration count.
- mem_wr_ack  in  1  write accepted this cycle.
- busy  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse when the last pixel write is acked.
- range_err  out  1  sticky flag: a result outside the frame was dropped.
- pix_count  out  ADDR_BITS+1  pixels written this frame.

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO empty; mem_wr_req=0; mem_wr_addr=0; mem_wr_data=0; res_ready=0; busy=0; frame_done=0; range_err=0; pix_count=0; latched x_max/y_max=0. Asserting rst mid-frame drops mem_wr_req immediately and discards all buffered results.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last ack--> DONE.
  - DONE --start--> RUN.
  - start while in RUN is ignored.
- On start: latch x_max/y_max; compute total=(x_max+1)*(y_max+1) into ADDR_BITS+1 bits; clear pix_count and range_err; FIFO is empty by construction.
- res_ready = (state==RUN) && (fifo_count < FIFO_DEPTH). It is computed from registered state only; there is no full-FIFO bypass.
- Accept when res_valid && res_ready.
  - If res_x > x_max_l or res_y > y_max_l: drop the result and set range_err.
  - Otherwise push {addr, iter}, with addr = res_y*(x_max_l+1)+res_x computed at push time, truncated to ADDR_BITS.
- Simultaneous push and pop on the same edge are both performed; fifo_count is unchanged.
- Write port:
  - When mem_wr_req=0 and the FIFO is non-empty, pop the head into mem_wr_addr/mem_wr_data and raise mem_wr_req on the next edge. Minimum latency is 2 cycles from the accepting edge to mem_wr_req high.
  - mem_wr_addr/mem_wr_data are stable while mem_wr_req=1.
  - A cycle with mem_wr_req && mem_wr_ack completes the write and increments pix_count.
  - In that same cycle, if the FIFO is non-empty, the next head is loaded and mem_wr_req stays high (back-to-back writes). Otherwise mem_wr_req falls.
  - mem_wr_ack while mem_wr_req=0 is ignored.
- Completion: on the ack that makes pix_count==total, pulse frame_done for one cycle, move to DONE, drop busy and res_ready.
- Duplicate coordinates are not detected; each one counts toward total.
- Pixel-count wrap: pix_count cannot exceed total because res_ready is low in DONE.

Decomposition:
- Package pix_pkg: state enum (IDLE, RUN, DONE), a FIFO entry struct {addr, iter}, and default width constants shared with the dispatcher.
- One sub-module, pix_fifo: synchronous FIFO with parameterised depth/width, push/pop/full/empty/count, async active-high rst.
- Address multiply, FSM and write port stay in pix_collect.

Test Plan:
- 2x2 frame: x_max=1, y_max=1, start, then results (0,0,5),(1,0,6),(0,1,7),(1,1,8) with mem_wr_ack tied high -> writes addr 0,1,2,3 with data 5,6,7,8; pix_count=4; frame_done pulses once; busy=0.
- Backpressure: FIFO_DEPTH=4, mem_wr_ack held low, 6 results offered -> 1 result in the write register plus 4 in the FIFO, so res_ready=0 after the fifth accept; releasing ack drains all 5 in order.
- Out of range: x_max=2, y_max=2, result (3,0,9) -> no write, range_err=1, pix_count unchanged; a subsequent start clears range_err.
- Out-of-order arrival: 4x1 frame (x_max=3, y_max=0), results x=3,0,2,1 -> addresses 3,0,2,1 in arrival order; frame_done pulses after the 4th ack.
- Reset mid-frame: assert rst while mem_wr_req=1 with 2 entries buffered -> mem_wr_req=0 immediately, state IDLE, pix_count=0; a new start runs a clean 2x2 frame.
- Start while in RUN is ignored: pix_count continues without clearing; start in DONE restarts with new x_max/y_max.
